// File: rtl/laserdrop_pkg.sv
// Shared types for the laserdrop FTDI echo blocks: FSM states, mode and
// packet phase encodings, plus a small helper for parameter arithmetic.
package laserdrop_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_LOW   = 3'd1,
    RD_HIGH  = 3'd2,
    WR_SETUP = 3'd3,
    WR_LOW   = 3'd4,
    WR_HIGH  = 3'd5
  } echo_state_t;

  typedef enum logic {
    MODE_STREAM = 1'b0,
    MODE_PACKET = 1'b1
  } echo_mode_t;

  typedef enum logic {
    PHASE_FILL  = 1'b0,
    PHASE_DRAIN = 1'b1
  } pkt_phase_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/echo_fifo.sv
// Circular byte buffer for the echo path. Pointers wrap modulo DEPTH
// (power of two); a separate occupancy counter distinguishes full from
// empty. Push when full and pop when empty are ignored.
module echo_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 512
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == LW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];
  assign level   = count;

  // Storage array; contents are not reset, the pointers define validity.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy bookkeeping, cleared by the synchronous reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/packet_echo.sv
// FTDI async-FIFO echo engine. Reads bytes from the FTDI chip into a
// buffer and writes them back XORed with a key, either as a continuous
// stream or in fill-then-drain packets. Handshake timing lives here; the
// buffer itself is echo_fifo.
module packet_echo
  import laserdrop_pkg::*;
#(
  parameter int DEPTH     = 512,
  parameter int PKT_BYTES = 512,
  parameter int RD_PULSE  = 2,
  parameter int WR_PULSE  = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     en,
  input  logic                     pkt_mode,
  input  logic [7:0]               xor_key,
  input  logic                     rxf,
  input  logic                     txe,
  input  logic [7:0]               adbus_in,
  output logic [7:0]               adbus_out,
  output logic                     adbus_tri,
  output logic                     ftdi_rd,
  output logic                     ftdi_wr,
  output logic [$clog2(DEPTH):0]   level,
  output logic [$clog2(DEPTH):0]   rd_ct,
  output logic                     pkt_done,
  output logic [15:0]              pkt_count
);

  localparam int LW        = $clog2(DEPTH) + 1;
  localparam int PULSE_MAX = max_int(RD_PULSE, WR_PULSE);
  localparam int CW        = (PULSE_MAX > 1) ? $clog2(PULSE_MAX) : 1;
  localparam logic [LW-1:0] PKT_LIMIT = LW'(PKT_BYTES);

  echo_state_t   state_q;
  echo_state_t   state_d;
  logic [CW-1:0] cnt_q;
  echo_mode_t    mode_q;
  pkt_phase_t    phase_q;
  logic [LW-1:0] rd_ct_q;
  logic [15:0]   pkt_count_q;
  logic          pkt_done_q;
  logic [7:0]    out_q;

  logic [7:0]    head;
  logic [LW-1:0] fifo_level;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          rd_ok;
  logic          wr_ok;
  logic          rd_last;
  logic          wr_last;
  logic          pkt_end;

  echo_fifo #(
    .WIDTH(8),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (adbus_in),
    .head  (head),
    .level (fifo_level),
    .full  (full),
    .empty (empty)
  );

  assign rd_last = (cnt_q == CW'(RD_PULSE - 1));
  assign wr_last = (cnt_q == CW'(WR_PULSE - 1));

  // The last byte of a packet leaves the buffer: packet mode needs the
  // drain phase, stream mode needs a saturated read count.
  assign pkt_end = pop && (fifo_level == LW'(1)) &&
                   ((mode_q == MODE_PACKET) ? (phase_q == PHASE_DRAIN)
                                            : (rd_ct_q == PKT_LIMIT));

  assign adbus_out = out_q;
  assign level     = fifo_level;
  assign rd_ct     = rd_ct_q;
  assign pkt_done  = pkt_done_q;
  assign pkt_count = pkt_count_q;

  // Decide which transaction IDLE may start, from the live mode input.
  always_comb begin
    rd_ok = 1'b0;
    wr_ok = 1'b0;
    if (pkt_mode) begin
      rd_ok = (phase_q == PHASE_FILL) && !rxf && !full && (rd_ct_q < PKT_LIMIT);
      wr_ok = (phase_q == PHASE_DRAIN) && !txe && !empty;
    end else begin
      rd_ok = !rxf && !full;
      wr_ok = !txe && !empty;
    end
  end

  // State register.
  always_ff @(posedge clock) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; reads take priority over writes when both are allowed.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (en && rd_ok)      state_d = RD_LOW;
        else if (en && wr_ok) state_d = WR_SETUP;
      end
      RD_LOW:   if (rd_last) state_d = RD_HIGH;
      RD_HIGH:  state_d = IDLE;
      WR_SETUP: state_d = WR_LOW;
      WR_LOW:   if (wr_last) state_d = WR_HIGH;
      WR_HIGH:  state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Strobes, bus direction and buffer push/pop decoded from the state.
  always_comb begin
    ftdi_rd   = 1'b1;
    ftdi_wr   = 1'b1;
    adbus_tri = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    unique case (state_q)
      RD_LOW: begin
        ftdi_rd = 1'b0;
        push    = rd_last;
      end
      WR_SETUP: adbus_tri = 1'b1;
      WR_LOW: begin
        ftdi_wr   = 1'b0;
        adbus_tri = 1'b1;
        pop       = wr_last;
      end
      WR_HIGH:  adbus_tri = 1'b1;
      default: begin
        ftdi_rd   = 1'b1;
        ftdi_wr   = 1'b1;
      end
    endcase
  end

  // Strobe-width counter, restarted on every entry to a low-pulse state.
  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if ((state_q == RD_LOW || state_q == WR_LOW) && state_d == state_q) begin
      cnt_q <= cnt_q + CW'(1);
    end else begin
      cnt_q <= '0;
    end
  end

  // Latch the mode and the keyed output byte when a transaction starts, so
  // input changes during the transaction cannot disturb it.
  always_ff @(posedge clock) begin
    if (!reset) begin
      mode_q <= MODE_STREAM;
      out_q  <= '0;
    end else if (state_q == IDLE) begin
      if (state_d != IDLE)     mode_q <= echo_mode_t'(pkt_mode);
      if (state_d == WR_SETUP) out_q  <= head ^ xor_key;
    end
  end

  // Packet bookkeeping: read count, fill/drain phase, done pulse, counter.
  always_ff @(posedge clock) begin
    if (!reset) begin
      rd_ct_q     <= '0;
      phase_q     <= PHASE_FILL;
      pkt_done_q  <= 1'b0;
      pkt_count_q <= '0;
    end else begin
      pkt_done_q <= pkt_end;
      if (pkt_end) begin
        rd_ct_q     <= '0;
        phase_q     <= PHASE_FILL;
        pkt_count_q <= pkt_count_q + 16'd1;
      end else if (push && rd_ct_q != PKT_LIMIT) begin
        rd_ct_q <= rd_ct_q + LW'(1);
        if (rd_ct_q == PKT_LIMIT - LW'(1)) phase_q <= PHASE_DRAIN;
      end
    end
  end

endmodule

// File: tb/tb_packet_echo.sv
// Self-checking bench for packet_echo (DEPTH=8, PKT_BYTES=4). The bench
// plays the FTDI chip: offered bytes sit in a source queue, and their keyed
// echo is queued as the expected write data. A negedge monitor checks
// strobe widths, bus direction and every written byte against that queue.
module tb_packet_echo;

  localparam int DEPTH     = 8;
  localparam int PKT_BYTES = 4;
  localparam int RD_PULSE  = 2;
  localparam int WR_PULSE  = 2;
  localparam int LW        = $clog2(DEPTH) + 1;

  logic          clock;
  logic          reset;
  logic          en;
  logic          pkt_mode;
  logic [7:0]    xor_key;
  logic          rxf;
  logic          txe;
  logic [7:0]    adbus_in;
  logic [7:0]    adbus_out;
  logic          adbus_tri;
  logic          ftdi_rd;
  logic          ftdi_wr;
  logic [LW-1:0] level;
  logic [LW-1:0] rd_ct;
  logic          pkt_done;
  logic [15:0]   pkt_count;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] src_q[$];
  logic [7:0] exp_q[$];

  int   rd_count;
  int   wr_count;
  int   done_count;
  int   rd_at_first_wr;
  int   level_at_wr_high;
  int   first_strobe;
  logic watch_order;

  packet_echo #(
    .DEPTH(DEPTH),
    .PKT_BYTES(PKT_BYTES),
    .RD_PULSE(RD_PULSE),
    .WR_PULSE(WR_PULSE)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .en        (en),
    .pkt_mode  (pkt_mode),
    .xor_key   (xor_key),
    .rxf       (rxf),
    .txe       (txe),
    .adbus_in  (adbus_in),
    .adbus_out (adbus_out),
    .adbus_tri (adbus_tri),
    .ftdi_rd   (ftdi_rd),
    .ftdi_wr   (ftdi_wr),
    .level     (level),
    .rd_ct     (rd_ct),
    .pkt_done  (pkt_done),
    .pkt_count (pkt_count)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // FTDI receive side: rxf low while a byte is offered, bus shows the front byte.
  task automatic update_rx();
    rxf      = (src_q.size() == 0);
    adbus_in = (src_q.size() > 0) ? src_q[0] : 8'h00;
  endtask

  task automatic apply_stimulus(input logic [7:0] b);
    src_q.push_back(b);
    exp_q.push_back(b ^ xor_key);
    update_rx();
  endtask

  task automatic clear_scoreboard();
    src_q.delete();
    exp_q.delete();
    rd_count       = 0;
    wr_count       = 0;
    done_count     = 0;
    rd_at_first_wr = -1;
    update_rx();
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    clear_scoreboard();
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic wait_rd(input int n, input int budget, input string tag);
    int k = 0;
    while (rd_count < n && k < budget) begin
      @(negedge clock);
      k++;
    end
    if (rd_count < n) check_output(tag, rd_count, n);
  endtask

  task automatic wait_wr(input int n, input int budget, input string tag);
    int k = 0;
    while (wr_count < n && k < budget) begin
      @(negedge clock);
      k++;
    end
    if (wr_count < n) check_output(tag, wr_count, n);
  endtask

  // Negedge monitor: FTDI consumer of reads, checker of every write.
  initial begin
    int         rd_low_len;
    int         wr_low_len;
    logic       prev_rd;
    logic       prev_wr;
    logic       prev_tri;
    logic [7:0] prev_out;
    rd_low_len = 0;
    wr_low_len = 0;
    prev_rd    = 1'b1;
    prev_wr    = 1'b1;
    prev_tri   = 1'b0;
    prev_out   = 8'h00;
    forever begin
      @(negedge clock);
      if (!reset) begin
        rd_low_len = 0;
        wr_low_len = 0;
        prev_rd    = 1'b1;
        prev_wr    = 1'b1;
        prev_tri   = 1'b0;
      end else begin
        if (!ftdi_rd) begin
          if (prev_rd && watch_order && first_strobe == 0) first_strobe = 1;
          rd_low_len++;
        end else if (!prev_rd) begin
          check_output("rd_pulse_width", rd_low_len, RD_PULSE);
          rd_low_len = 0;
          if (src_q.size() > 0) void'(src_q.pop_front());
          rd_count++;
        end
        if (!ftdi_wr) begin
          if (prev_wr) begin
            if (watch_order && first_strobe == 0) first_strobe = 2;
            if (wr_count == 0 && rd_at_first_wr < 0) rd_at_first_wr = rd_count;
            check_output("wr_setup_tri", 32'(prev_tri), 1);
            check_output("wr_data_stable", 32'(adbus_out), 32'(prev_out));
            check_output("wr_low_tri", 32'(adbus_tri), 1);
            if (exp_q.size() == 0) check_output("wr_unexpected", 32'(adbus_out), 32'hFFFF_FFFF);
            else                   check_output("wr_data", 32'(adbus_out), 32'(exp_q.pop_front()));
          end
          wr_low_len++;
        end else if (!prev_wr) begin
          check_output("wr_pulse_width", wr_low_len, WR_PULSE);
          check_output("wr_high_tri", 32'(adbus_tri), 1);
          level_at_wr_high = int'(level);
          wr_low_len = 0;
          wr_count++;
        end
        if (pkt_done) done_count++;
        prev_rd  = ftdi_rd;
        prev_wr  = ftdi_wr;
        prev_tri = adbus_tri;
        prev_out = adbus_out;
      end
      update_rx();
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lows;
    reset        = 1'b0;
    en           = 1'b1;
    pkt_mode     = 1'b0;
    xor_key      = 8'h00;
    txe          = 1'b1;
    watch_order  = 1'b0;
    first_strobe = 0;
    level_at_wr_high = -1;
    clear_scoreboard();
    settle(3);

    $display("[TB] reset values");
    check_output("rst_ftdi_rd",   32'(ftdi_rd),   1);
    check_output("rst_ftdi_wr",   32'(ftdi_wr),   1);
    check_output("rst_adbus_tri", 32'(adbus_tri), 0);
    check_output("rst_adbus_out", 32'(adbus_out), 0);
    check_output("rst_level",     32'(level),     0);
    check_output("rst_rd_ct",     32'(rd_ct),     0);
    check_output("rst_pkt_done",  32'(pkt_done),  0);
    check_output("rst_pkt_count", 32'(pkt_count), 0);
    reset = 1'b1;
    settle(1);

    $display("[TB] packet mode echo, key 00");
    pkt_mode = 1'b1;
    xor_key  = 8'h00;
    txe      = 1'b0;
    apply_stimulus(8'h11);
    apply_stimulus(8'h22);
    apply_stimulus(8'h33);
    apply_stimulus(8'h44);
    wait_wr(4, 300, "pkt_timeout");
    settle(3);
    check_output("pkt_reads_before_write", rd_at_first_wr, 4);
    check_output("pkt_done_pulses", done_count, 1);
    check_output("pkt_count_one",   32'(pkt_count), 1);
    check_output("pkt_rd_ct_clear", 32'(rd_ct), 0);
    check_output("pkt_level_empty", 32'(level), 0);

    $display("[TB] reset during WR_LOW");
    pkt_mode = 1'b0;
    xor_key  = 8'h0F;
    apply_stimulus(8'h77);
    lows = 0;
    while (ftdi_wr && lows < 60) begin
      @(negedge clock);
      lows++;
    end
    check_output("midwr_reached_wr_low", 32'(ftdi_wr), 0);
    check_output("midwr_count_before", 32'(pkt_count), 1);
    reset = 1'b0;
    @(negedge clock);
    check_output("midwr_ftdi_wr",   32'(ftdi_wr),   1);
    check_output("midwr_adbus_tri", 32'(adbus_tri), 0);
    check_output("midwr_level",     32'(level),     0);
    check_output("midwr_pkt_count", 32'(pkt_count), 0);
    reset = 1'b1;
    clear_scoreboard();

    $display("[TB] stream single byte, key FF");
    do_reset();
    pkt_mode = 1'b0;
    xor_key  = 8'hFF;
    txe      = 1'b0;
    apply_stimulus(8'hA5);
    wait_wr(1, 60, "single_timeout");
    settle(3);
    check_output("single_no_done", done_count, 0);
    check_output("single_level",   32'(level), 0);
    check_output("single_rd_ct",   32'(rd_ct), 1);

    $display("[TB] stream fill to full with txe high");
    do_reset();
    pkt_mode = 1'b0;
    xor_key  = 8'h3C;
    txe      = 1'b1;
    for (int i = 0; i < 9; i++) apply_stimulus(8'(8'h50 + i * 7));
    wait_rd(8, 200, "full_timeout");
    settle(2);
    check_output("full_level", 32'(level), 8);
    lows = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (!ftdi_rd) lows++;
    end
    check_output("full_rd_held_high", lows, 0);
    check_output("full_rd_count", rd_count, 8);
    txe = 1'b0;
    wait_wr(1, 60, "full_first_wr_timeout");
    check_output("full_level_after_wr", level_at_wr_high, 7);
    wait_wr(9, 400, "full_drain_timeout");
    settle(3);
    check_output("full_drained",   32'(level), 0);
    check_output("full_done",      done_count, 1);
    check_output("full_pkt_count", 32'(pkt_count), 1);
    check_output("full_rd_ct",     32'(rd_ct), 0);

    $display("[TB] read priority with level 3");
    do_reset();
    pkt_mode = 1'b0;
    xor_key  = 8'h00;
    txe      = 1'b1;
    apply_stimulus(8'hC1);
    apply_stimulus(8'hC2);
    apply_stimulus(8'hC3);
    wait_rd(3, 100, "prio_fill_timeout");
    settle(2);
    check_output("prio_level3", 32'(level), 3);
    first_strobe = 0;
    watch_order  = 1'b1;
    txe          = 1'b0;
    apply_stimulus(8'hC4);
    wait_wr(4, 300, "prio_timeout");
    settle(3);
    watch_order = 1'b0;
    check_output("prio_read_first", first_strobe, 1);
    check_output("prio_rd_count",   rd_count, 4);
    check_output("prio_level",      32'(level), 0);

    $display("[TB] pkt_count wrap");
    do_reset();
    pkt_mode = 1'b1;
    xor_key  = 8'hA0;
    txe      = 1'b0;
    @(negedge clock);
    force dut.pkt_count_q = 16'hFFFE;
    @(negedge clock);
    release dut.pkt_count_q;
    @(negedge clock);
    check_output("wrap_preload", 32'(pkt_count), 32'hFFFE);
    for (int i = 0; i < 4; i++) apply_stimulus(8'(8'h01 << i));
    wait_wr(4, 300, "wrap_a_timeout");
    settle(3);
    check_output("wrap_ffff", 32'(pkt_count), 32'hFFFF);
    for (int i = 0; i < 4; i++) apply_stimulus(8'(8'hF0 + i));
    wait_wr(8, 300, "wrap_b_timeout");
    settle(3);
    check_output("wrap_zero",  32'(pkt_count), 0);
    check_output("wrap_done",  done_count, 2);
    check_output("wrap_exp_q", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
